// File: rtl/ulx3s_input_pkg.sv
// Shared types and constants for the ULX3S Spacewar! input front end:
// mode and FSM encodings, button/joystick bit positions, mapping helpers.
package ulx3s_input_pkg;

  // Player-mapping modes, encoded as they appear on the mode output.
  typedef enum logic [1:0] {
    MODE_P1    = 2'd0,
    MODE_P2    = 2'd1,
    MODE_SPLIT = 2'd2
  } mode_e;

  // Mode-change FSM states.
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  // Board button indices; only the first N_MAPPED reach the joystick bus.
  localparam int BTN_FIRE1 = 0;
  localparam int BTN_UP    = 1;
  localparam int BTN_FIRE2 = 2;
  localparam int BTN_LEFT  = 3;
  localparam int BTN_RIGHT = 4;
  localparam int BTN_F1    = 5;
  localparam int BTN_F2    = 6;
  localparam int N_MAPPED  = 7;

  // joystick_emu bit positions as consumed by the PDP-1 core.
  localparam int JS_P1_FIRE   = 0;
  localparam int JS_P1_CCW    = 1;
  localparam int JS_P1_THRUST = 2;
  localparam int JS_P1_CW     = 3;
  localparam int JS_P2_FIRE   = 4;
  localparam int JS_P2_CCW    = 5;
  localparam int JS_P2_THRUST = 6;
  localparam int JS_P2_CW     = 7;

  // DIP decode: SPLIT has priority over P2; anything else is P1.
  function automatic mode_e decode_mode(input logic split_sel, input logic p2_sel);
    mode_e m;
    if (split_sel)   m = MODE_SPLIT;
    else if (p2_sel) m = MODE_P2;
    else             m = MODE_P1;
    return m;
  endfunction

  // Button levels -> joystick bits. The fire positions of lvl already
  // carry the autofire gating, so this is a pure routing table.
  function automatic logic [7:0] map_joystick(input mode_e m,
                                              input logic [N_MAPPED-1:0] lvl);
    logic [7:0] js;
    js = '0;
    case (m)
      MODE_P1: begin
        js[JS_P1_FIRE]   = lvl[BTN_FIRE1];
        js[JS_P1_THRUST] = lvl[BTN_UP];
        js[JS_P1_CCW]    = lvl[BTN_LEFT];
        js[JS_P1_CW]     = lvl[BTN_RIGHT];
      end
      MODE_P2: begin
        js[JS_P2_FIRE]   = lvl[BTN_FIRE2];
        js[JS_P2_THRUST] = lvl[BTN_UP];
        js[JS_P2_CCW]    = lvl[BTN_LEFT];
        js[JS_P2_CW]     = lvl[BTN_RIGHT];
      end
      MODE_SPLIT: begin
        js[JS_P1_FIRE]   = lvl[BTN_FIRE1];
        js[JS_P1_THRUST] = lvl[BTN_UP];
        js[JS_P1_CCW]    = lvl[BTN_LEFT];
        js[JS_P1_CW]     = lvl[BTN_RIGHT];
        // Player 2 has no thrust button in split mode.
        js[JS_P2_FIRE]   = lvl[BTN_FIRE2];
        js[JS_P2_CCW]    = lvl[BTN_F1];
        js[JS_P2_CW]     = lvl[BTN_F2];
      end
      default: js = '0;
    endcase
    return js;
  endfunction

endpackage

// File: rtl/ulx3s_input_ctrl_btn_debounce.sv
// Single-button debouncer: the synchronised input must disagree with the
// committed level for DEBOUNCE_MS consecutive 1 ms ticks before the level
// follows it. rise/fall pulse for one cycle together with the level change.
module btn_debounce #(
  parameter int DEBOUNCE_MS = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic sync,
  input  logic tick,
  output logic level,
  output logic rise,
  output logic fall
);

  // Commit happens on the tick that would take the count to DEBOUNCE_MS.
  localparam logic [7:0] LAST_COUNT = 8'(DEBOUNCE_MS - 1);

  logic [7:0] count;

  // Count ticks of disagreement; any agreement restarts the count.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values; the pulse defaults below are overridden later in
    // the same block, which is the intended last-assignment-wins behaviour.
    rise <= 1'b0;
    fall <= 1'b0;
    if (rst) begin
      count <= '0;
      level <= 1'b0;
    end else if (sync == level) begin
      count <= '0;
    end else if (tick) begin
      if (count == LAST_COUNT) begin
        level <= sync;
        count <= '0;
        rise  <= sync;
        fall  <= ~sync;
      end else begin
        count <= count + 8'd1;
      end
    end
  end

endmodule

// File: rtl/ulx3s_input_ctrl.sv
// ULX3S button/DIP front end for PDP-1 Spacewar!: synchronises and
// debounces the board buttons, selects a player mapping from the DIP
// switches through a drain FSM, applies optional autofire and drives the
// registered joystick_emu bus.
module ulx3s_input_ctrl
  import ulx3s_input_pkg::*;
#(
  parameter int CLK_FREQ     = 25_000_000,
  parameter int N_BTN        = 7,
  parameter int DEBOUNCE_MS  = 10,
  parameter int AF_PERIOD_MS = 125
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_n,
  input  logic [3:0]       sw,
  output logic [7:0]       joystick_emu,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [1:0]       mode,
  output logic             draining,
  output logic [7:0]       led_feedback
);

  localparam int TICK_DIV = CLK_FREQ / 1000;
  localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  // Autofire runs symmetric half-periods; an odd period rounds down.
  localparam int AF_HALF  = AF_PERIOD_MS / 2;
  localparam int AF_LEN   = 2 * AF_HALF;
  localparam int AF_W     = $clog2(AF_LEN + 1);

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;
  logic [N_BTN-1:0] btn_meta, btn_sync;
  logic [2:0]       sw_meta, sw_sync;
  logic             sw_unused;

  state_e           state, next_state;
  mode_e            cur_mode, next_mode, req_mode;
  logic             af_en;
  logic [AF_W-1:0]  af_cnt [2];
  logic [1:0]       fire_level, fire_press, fire_eff;
  logic [N_MAPPED-1:0] lvl_eff;
  logic [7:0]       js_next;

  // sw[3] is a reserved switch position with no function.
  assign sw_unused = sw[3];

  // 1 ms prescaler; tick is high for the terminal-count cycle.
  always_ff @(posedge clk) begin
    if (rst || tick) pre_cnt <= '0;
    else             pre_cnt <= pre_cnt + PRE_W'(1);
  end
  assign tick = (pre_cnt == PRE_W'(TICK_DIV - 1));

  // Two-flop synchronisers; buttons are inverted to active-high first.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_meta <= '0;
      btn_sync <= '0;
      sw_meta  <= '0;
      sw_sync  <= '0;
    end else begin
      btn_meta <= ~btn_n;
      btn_sync <= btn_meta;
      sw_meta  <= sw[2:0];
      sw_sync  <= sw_meta;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_MS(DEBOUNCE_MS)
    ) u_debounce (
      .clk  (clk),
      .rst  (rst),
      .sync (btn_sync[i]),
      .tick (tick),
      .level(btn_level[i]),
      .rise (btn_press[i]),
      .fall (btn_release[i])
    );
  end

  assign req_mode   = decode_mode(sw_sync[1], sw_sync[0]);
  assign af_en      = sw_sync[2];
  assign fire_level = {btn_level[BTN_FIRE2], btn_level[BTN_FIRE1]};
  assign fire_press = {btn_press[BTN_FIRE2], btn_press[BTN_FIRE1]};

  // Autofire phase per player; a press restarts the phase at the high half.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (rst || fire_press[p])
        af_cnt[p] <= '0;
      else if (tick)
        af_cnt[p] <= (af_cnt[p] == AF_W'(AF_LEN - 1)) ? '0 : af_cnt[p] + AF_W'(1);
    end
  end

  // Fire gating; the press cycle counts as phase 0 so the output rises
  // on the very next edge instead of waiting for the cleared counter.
  always_comb begin
    fire_eff = '0;
    for (int p = 0; p < 2; p++) begin
      fire_eff[p] = fire_level[p] &&
                    (!af_en || fire_press[p] || (af_cnt[p] < AF_W'(AF_HALF)));
    end
  end

  // Mapped levels with the autofire-gated fire buttons substituted in.
  always_comb begin
    lvl_eff            = btn_level[N_MAPPED-1:0];
    lvl_eff[BTN_FIRE1] = fire_eff[0];
    lvl_eff[BTN_FIRE2] = fire_eff[1];
  end

  // Mode FSM next-state and joystick next value; DRAIN holds the bus at 0
  // until every mapped button is released so no control leaks across modes.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    next_state = state;
    next_mode  = cur_mode;
    js_next    = '0;
    case (state)
      ST_RUN: begin
        if (req_mode != cur_mode) next_state = ST_DRAIN;
        else                      js_next    = map_joystick(cur_mode, lvl_eff);
      end
      ST_DRAIN: begin
        if (btn_level[N_MAPPED-1:0] == '0) begin
          next_state = ST_RUN;
          next_mode  = req_mode;
        end
      end
      default: next_state = ST_RUN;
    endcase
  end

  // FSM, active mode and the registered joystick bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_RUN;
      cur_mode     <= MODE_P1;
      joystick_emu <= '0;
    end else begin
      state        <= next_state;
      cur_mode     <= next_mode;
      joystick_emu <= js_next;
    end
  end

  assign mode         = cur_mode;
  assign draining     = (state == ST_DRAIN);
  assign led_feedback = joystick_emu;

endmodule

// File: tb/tb_ulx3s_input_ctrl.sv
// Directed bench for ulx3s_input_ctrl. The DUT runs with a 100 kHz clock
// parameter so one 1 ms tick is 100 cycles, keeping the run short while
// the debounce and autofire periods stay at their millisecond values.
module tb_ulx3s_input_ctrl;

  localparam int N_BTN = 8;
  localparam int TICK  = 100;

  logic             clk;
  logic             rst;
  logic [N_BTN-1:0] btn_n;
  logic [3:0]       sw;
  logic [7:0]       joystick_emu;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [1:0]       mode;
  logic             draining;
  logic [7:0]       led_feedback;

  int tests = 0;
  int fails = 0;

  ulx3s_input_ctrl #(
    .CLK_FREQ    (TICK * 1000),
    .N_BTN       (N_BTN),
    .DEBOUNCE_MS (10),
    .AF_PERIOD_MS(125)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_n       (btn_n),
    .sw          (sw),
    .joystick_emu(joystick_emu),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .mode        (mode),
    .draining    (draining),
    .led_feedback(led_feedback)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; btn_n = '1; sw = 4'b0000;
    cyc(3);
    tests++; if (joystick_emu !== 8'h00) begin fails++; $display("FAIL reset_js: got %h expected 00", joystick_emu); end
    tests++; if (btn_level !== 8'h00) begin fails++; $display("FAIL reset_level: got %h expected 00", btn_level); end
    tests++; if (mode !== 2'd0) begin fails++; $display("FAIL reset_mode: got %0d expected 0", mode); end
    tests++; if (draining !== 1'b0) begin fails++; $display("FAIL reset_draining: got %b expected 0", draining); end
    tests++; if (led_feedback !== 8'h00) begin fails++; $display("FAIL reset_led: got %h expected 00", led_feedback); end
    rst = 1'b0;
    cyc(2);
  endtask

  // Scenario 1: hold fire 1 in P1; one press pulse ~10 ms in, bus 01 a cycle later.
  task automatic test_press;
    int press_at = -1, pulses = 0, rels = 0;
    logic [7:0] js_after = 8'hxx;
    logic lvl_at_press = 1'b0;
    btn_n[0] = 1'b0;
    for (int i = 1; i <= 12 * TICK; i++) begin
      cyc(1);
      if (btn_press[0]) begin
        pulses++;
        if (press_at < 0) begin press_at = i; lvl_at_press = btn_level[0]; end
      end
      if (press_at > 0 && i == press_at + 1) js_after = joystick_emu;
    end
    tests++; if (pulses != 1) begin fails++; $display("FAIL press_pulses: got %0d expected 1", pulses); end
    tests++; if (press_at < 9 * TICK || press_at > 10 * TICK + 10) begin fails++; $display("FAIL press_latency: got %0d expected 900..1010", press_at); end
    tests++; if (lvl_at_press !== 1'b1) begin fails++; $display("FAIL press_level_same_cycle: got %b expected 1", lvl_at_press); end
    tests++; if (js_after !== 8'h01) begin fails++; $display("FAIL press_js: got %h expected 01", js_after); end
    btn_n[0] = 1'b1;
    for (int i = 1; i <= 12 * TICK; i++) begin
      cyc(1);
      if (btn_release[0]) rels++;
    end
    tests++; if (rels != 1) begin fails++; $display("FAIL release_pulses: got %0d expected 1", rels); end
    tests++; if (joystick_emu !== 8'h00) begin fails++; $display("FAIL release_js: got %h expected 00", joystick_emu); end
  endtask

  // Scenario 2: five glitches shorter than a tick never reach the level.
  task automatic test_glitch;
    int presses = 0;
    logic seen_high = 1'b0;
    repeat (5) begin
      btn_n[3] = 1'b0;
      for (int i = 0; i < 60; i++) begin
        cyc(1);
        if (btn_press[3]) presses++;
        if (btn_level[3]) seen_high = 1'b1;
      end
      btn_n[3] = 1'b1;
      for (int i = 0; i < TICK; i++) begin
        cyc(1);
        if (btn_press[3]) presses++;
        if (btn_level[3]) seen_high = 1'b1;
      end
    end
    for (int i = 0; i < 11 * TICK; i++) begin
      cyc(1);
      if (btn_press[3]) presses++;
      if (btn_level[3]) seen_high = 1'b1;
    end
    tests++; if (presses != 0) begin fails++; $display("FAIL glitch_press: got %0d expected 0", presses); end
    tests++; if (seen_high !== 1'b0) begin fails++; $display("FAIL glitch_level: got %b expected 0", seen_high); end
  endtask

  // Scenario 3: mode change while thrust is held waits in DRAIN.
  task automatic test_mode_drain;
    int bad = 0, exit_at = -1, leak = 0;
    btn_n[1] = 1'b0;
    cyc(11 * TICK);
    tests++; if (joystick_emu !== 8'h04) begin fails++; $display("FAIL drain_pre_js: got %h expected 04", joystick_emu); end
    sw = 4'b0001;
    cyc(5);
    tests++; if (draining !== 1'b1) begin fails++; $display("FAIL drain_enter: got %b expected 1", draining); end
    tests++; if (joystick_emu !== 8'h00) begin fails++; $display("FAIL drain_js: got %h expected 00", joystick_emu); end
    tests++; if (mode !== 2'd0) begin fails++; $display("FAIL drain_mode_held: got %0d expected 0", mode); end
    for (int i = 0; i < 3 * TICK; i++) begin
      cyc(1);
      if (joystick_emu !== 8'h00 || draining !== 1'b1) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL drain_hold: got %0d bad cycles expected 0", bad); end
    btn_n[1] = 1'b1;
    for (int i = 1; i <= 12 * TICK; i++) begin
      cyc(1);
      if (joystick_emu !== 8'h00) leak++;
      if (draining === 1'b0) begin exit_at = i; break; end
    end
    tests++; if (exit_at < 0) begin fails++; $display("FAIL drain_exit: got timeout expected exit within 1200 cycles"); end
    tests++; if (leak != 0) begin fails++; $display("FAIL drain_leak: got %0d nonzero cycles expected 0", leak); end
    tests++; if (mode !== 2'd1) begin fails++; $display("FAIL drain_new_mode: got %0d expected 1", mode); end
    btn_n[2] = 1'b0;
    cyc(11 * TICK);
    tests++; if (joystick_emu !== 8'h10) begin fails++; $display("FAIL p2_fire_js: got %h expected 10", joystick_emu); end
    btn_n[2] = 1'b1;
    cyc(11 * TICK);
    tests++; if (joystick_emu !== 8'h00) begin fails++; $display("FAIL p2_release_js: got %h expected 00", joystick_emu); end
  endtask

  // Scenario 4: SPLIT mapping, same-cycle press/release, unmapped button.
  task automatic test_split;
    int drain_cycles = 0, rel_at = -1;
    logic press6_same = 1'b0;
    sw = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (draining) drain_cycles++;
    end
    tests++; if (drain_cycles != 1) begin fails++; $display("FAIL split_drain_len: got %0d expected 1", drain_cycles); end
    tests++; if (mode !== 2'd2) begin fails++; $display("FAIL split_mode: got %0d expected 2", mode); end
    btn_n[5] = 1'b0; btn_n[0] = 1'b0;
    cyc(11 * TICK);
    tests++; if (joystick_emu !== 8'h21) begin fails++; $display("FAIL split_js: got %h expected 21", joystick_emu); end
    tests++; if (led_feedback !== 8'h21) begin fails++; $display("FAIL split_led: got %h expected 21", led_feedback); end
    btn_n[5] = 1'b1; btn_n[6] = 1'b0;
    for (int i = 1; i <= 12 * TICK; i++) begin
      cyc(1);
      if (btn_release[5] && rel_at < 0) begin rel_at = i; press6_same = btn_press[6]; end
    end
    tests++; if (rel_at < 0) begin fails++; $display("FAIL simul_release: got none expected one pulse"); end
    tests++; if (press6_same !== 1'b1) begin fails++; $display("FAIL simul_press: got %b expected 1", press6_same); end
    tests++; if (joystick_emu !== 8'h81) begin fails++; $display("FAIL split_cw2_js: got %h expected 81", joystick_emu); end
    btn_n[0] = 1'b1; btn_n[6] = 1'b1;
    cyc(11 * TICK);
    btn_n[7] = 1'b0;
    cyc(11 * TICK);
    tests++; if (btn_level[7] !== 1'b1) begin fails++; $display("FAIL extra_level: got %b expected 1", btn_level[7]); end
    tests++; if (joystick_emu !== 8'h00) begin fails++; $display("FAIL extra_js: got %h expected 00", joystick_emu); end
    btn_n[7] = 1'b1;
    cyc(11 * TICK);
  endtask

  // Scenario 5: autofire in P1 toggles fire every 62 ticks (6200 cycles).
  task automatic test_autofire;
    int found = 0, rel = 0;
    logic js0_at_press, prev;
    int edges[$];
    sw = 4'b0100;
    cyc(10);
    tests++; if (mode !== 2'd0) begin fails++; $display("FAIL af_mode: got %0d expected 0", mode); end
    btn_n[0] = 1'b0;
    for (int i = 0; i < 15 * TICK; i++) begin
      cyc(1);
      if (btn_press[0]) begin found = 1; break; end
    end
    tests++; if (found != 1) begin fails++; $display("FAIL af_press: got timeout expected press pulse"); end
    js0_at_press = joystick_emu[0];
    cyc(1);
    tests++; if (js0_at_press !== 1'b0 || joystick_emu[0] !== 1'b1) begin
      fails++; $display("FAIL af_first_high: got %b->%b expected 0->1", js0_at_press, joystick_emu[0]);
    end
    prev = joystick_emu[0];
    for (int i = 2; i <= 300 * TICK; i++) begin
      cyc(1);
      if (joystick_emu[0] !== prev) begin edges.push_back(i); prev = joystick_emu[0]; end
    end
    tests++; if (edges.size() != 4) begin fails++; $display("FAIL af_edge_count: got %0d expected 4", edges.size()); end
    for (int k = 0; k < 4; k++) begin
      if (edges.size() > k) begin
        tests++;
        if (edges[k] != 62 * TICK * (k + 1) + 1) begin
          fails++; $display("FAIL af_edge%0d: got %0d expected %0d", k, edges[k], 62 * TICK * (k + 1) + 1);
        end
      end
    end
    btn_n[0] = 1'b1;
    for (int i = 0; i < 12 * TICK; i++) begin
      cyc(1);
      if (btn_release[0]) begin rel = 1; break; end
    end
    cyc(1);
    tests++; if (rel != 1 || joystick_emu[0] !== 1'b0) begin
      fails++; $display("FAIL af_release: got rel=%0d fire=%b expected rel=1 fire=0", rel, joystick_emu[0]);
    end
    sw = 4'b0000;
    cyc(5);
  endtask

  // Scenario 6: one-cycle reset while b4 is held and b1 is mid-count.
  task automatic test_reset_mid;
    int press_at = -1;
    btn_n[4] = 1'b0;
    cyc(11 * TICK);
    tests++; if (joystick_emu !== 8'h08) begin fails++; $display("FAIL rmid_pre_js: got %h expected 08", joystick_emu); end
    btn_n[1] = 1'b0;
    cyc(5 * TICK);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    tests++; if (joystick_emu !== 8'h00) begin fails++; $display("FAIL rmid_js: got %h expected 00", joystick_emu); end
    tests++; if (btn_level !== 8'h00) begin fails++; $display("FAIL rmid_level: got %h expected 00", btn_level); end
    tests++; if (mode !== 2'd0 || draining !== 1'b0) begin fails++; $display("FAIL rmid_mode: got %0d/%b expected 0/0", mode, draining); end
    for (int i = 1; i <= 12 * TICK; i++) begin
      cyc(1);
      if (btn_press[4]) begin press_at = i; break; end
    end
    tests++; if (press_at < 10 * TICK - 5 || press_at > 10 * TICK + 5) begin fails++; $display("FAIL rmid_redebounce: got %0d expected 995..1005", press_at); end
    tests++; if (btn_level[1] !== 1'b1) begin fails++; $display("FAIL rmid_b1_level: got %b expected 1", btn_level[1]); end
    cyc(1);
    tests++; if (joystick_emu !== 8'h0C) begin fails++; $display("FAIL rmid_post_js: got %h expected 0c", joystick_emu); end
    btn_n = '1;
    cyc(11 * TICK);
  endtask

  initial begin
    rst = 1'b1; btn_n = '1; sw = 4'b0000;
    test_reset();
    test_press();
    test_glitch();
    test_mode_drain();
    test_split();
    test_autofire();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
